float_to_int: RTL and testbench

Multi-cycle converter from IEEE-754 single precision to signed 32-bit two's-complement integer. It is the consumer side of the FP32 datapath: it takes results from the floating-point add pipeline and decodes them into fixed integers for the integer side of the accelerator. The alignment shift is iterative, at STEP bits per cycle. Valid/ready handshakes on both sides; one conversion in flight at a time.

---
 rtl/float_to_int.sv | 155 +++++++++++++++
 tb/tb_float_to_int.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_int.sv
// Iterative FP32 -> signed int32 converter with valid/ready on both sides.
// Build option: define ROUND_NEAREST_EN for round-to-nearest-even, otherwise truncate toward zero.
module float_to_int #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [5:0] STEP_C = 6'(STEP);

    logic [1:0]  state;
    logic        sign_q;
    logic [63:0] r_q;
    logic [5:0]  c_q;

    logic              in_sign;
    logic [7:0]        in_exp;
    logic [22:0]       in_frac;
    logic signed [8:0] exp_unb;
    logic [5:0]        c_init;

    assign in_sign = in_data[31];
    assign in_exp  = in_data[30:23];
    assign in_frac = in_data[22:0];
    assign exp_unb = signed'({1'b0, in_exp} - 9'd127);

    // Values below 0.25 all park the leading one at bit 30, so only sticky survives.
    assign c_init = (exp_unb <= -9'sd2) ? 6'd33 : 6'd31 - exp_unb[5:0];

    logic        is_special;
    logic [31:0] spec_data;
    logic [2:0]  spec_flags;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        is_special = 1'b0;
        spec_data  = 32'h0;
        spec_flags = 3'b000;
        if (in_exp == 8'hFF) begin
            is_special = 1'b1;
            if (|in_frac) begin
                spec_data  = 32'h7FFF_FFFF;
                spec_flags = 3'b100;
            end else begin
                spec_data  = in_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                spec_flags = 3'b010;
            end
        end else if (in_exp == 8'h00) begin
            is_special = 1'b1;
            spec_flags = {2'b00, |in_frac};
        end else if (exp_unb >= 9'sd31) begin
            is_special = 1'b1;
            if (in_sign && (exp_unb == 9'sd31) && (in_frac == 23'h0)) begin
                spec_data = 32'h8000_0000;
            end else begin
                spec_data  = in_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                spec_flags = 3'b010;
            end
        end
    end

    logic [5:0] amt;
    logic [5:0] c_next;

    assign amt    = (c_q < STEP_C) ? c_q : STEP_C;
    assign c_next = c_q - amt;

    logic [31:0] mag;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [31:0] mag_rnd;
    logic [31:0] result;

    assign mag    = r_q[63:32];
    assign guard  = r_q[31];
    assign sticky = |r_q[30:0];

`ifdef ROUND_NEAREST_EN
    assign round_up = guard & (sticky | mag[0]);
`else
    assign round_up = 1'b0;
`endif

    // The increment cannot carry out: guard/sticky are only set when the magnitude is below 2^23.
    assign mag_rnd = mag + {31'b0, round_up};
    assign result  = sign_q ? (32'h0 - mag_rnd) : mag_rnd;

    assign in_ready = rst_n & (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign_q    <= 1'b0;
            r_q       <= 64'h0;
            c_q       <= 6'h0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_flags <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        r_q    <= {1'b1, in_frac, 40'h0};
                        c_q    <= c_init;
                        if (is_special) begin
                            out_data  <= spec_data;
                            out_flags <= spec_flags;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_q <= r_q >> amt;
                    c_q <= c_next;
                    if (c_next == 6'd0) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_data  <= result;
                    out_flags <= {2'b00, guard | sticky};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: directed vectors, backpressure, mid-flight reset, STEP sweep.
module tb_float_to_int;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    float_to_int #(.STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags)
    );

    logic        sw_in_valid;
    logic [31:0] sw_in_data;
    logic        sw_out_ready;
    logic        sw_in_ready [3];
    logic        sw_out_valid[3];
    logic [31:0] sw_out_data [3];
    logic [2:0]  sw_out_flags[3];

    float_to_int #(.STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_in_valid), .in_ready(sw_in_ready[0]), .in_data(sw_in_data),
        .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[0]), .out_flags(sw_out_flags[0])
    );
    float_to_int #(.STEP(2)) u_s2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_in_valid), .in_ready(sw_in_ready[1]), .in_data(sw_in_data),
        .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[1]), .out_flags(sw_out_flags[1])
    );
    float_to_int #(.STEP(8)) u_s8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_in_valid), .in_ready(sw_in_ready[2]), .in_data(sw_in_data),
        .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[2]), .out_flags(sw_out_flags[2])
    );

`ifdef ROUND_NEAREST_EN
    localparam logic [31:0] R_1P5   = 32'h0000_0002;
    localparam logic [31:0] R_M3P5  = 32'hFFFF_FFFC;
    localparam logic [31:0] R_0P75  = 32'h0000_0001;
    localparam logic [31:0] R_M123  = 32'hFFFF_FF84;
`else
    localparam logic [31:0] R_1P5   = 32'h0000_0001;
    localparam logic [31:0] R_M3P5  = 32'hFFFF_FFFD;
    localparam logic [31:0] R_0P75  = 32'h0000_0000;
    localparam logic [31:0] R_M123  = 32'hFFFF_FF85;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [31:0] d;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    // Monitor: compares the first cycle of each result, then checks it holds until accepted.
    exp_t        cur;
    bit          seen = 1'b0;
    logic [31:0] held_d;
    logic [2:0]  held_f;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got out_data=0x%08h with no pending expectation", out_data);
                end else begin
                    cur = sb.pop_front();
                    check({cur.name, "_data"}, out_data, cur.data);
                    check({cur.name, "_flags"}, {29'h0, out_flags}, {29'h0, cur.flags});
                    check({cur.name, "_latency"}, 32'(cyc - cur.acc + 1), 32'(cur.lat));
                end
                seen   = 1'b1;
                held_d = out_data;
                held_f = out_flags;
            end else begin
                check("hold_data", out_data, held_d);
                check("hold_flags", {29'h0, out_flags}, {29'h0, held_f});
            end
            if (out_ready) seen = 1'b0;
        end
    end

    task automatic send(input string name, input logic [31:0] din, input logic [31:0] d,
                        input logic [2:0] f, input int lat, output int acc);
        int waited = 0;
        in_data  = din;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: got in_ready=0 for 200 cycles expected 1", name);
            in_valid = 1'b0;
            acc      = -1;
        end else begin
            acc = cyc + 1;
            sb.push_back('{data: d, flags: f, lat: lat, acc: acc, name: name});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb.size() != 0 || out_valid) && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int p0;
        int waited;
        int sw_acc;
        bit done[3];
        int sw_lat[3];

        vecs = '{
            '{"tie_1p5",   32'h3FC0_0000, R_1P5,         3'b001, 10},
            '{"neg_3p5",   32'hC060_0000, R_M3P5,        3'b001, 10},
            '{"half",      32'h3F00_0000, 32'h0,         3'b001, 10},
            '{"three_q",   32'h3F40_0000, R_0P75,        3'b001, 10},
            '{"denorm",    32'h0000_0001, 32'h0,         3'b001, 1},
            '{"min_int",   32'hCF00_0000, 32'h8000_0000, 3'b000, 1},
            '{"pos_ovf",   32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1},
            '{"max_fit",   32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 3},
            '{"nan",       32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100, 1},
            '{"neg_inf",   32'hFF80_0000, 32'h8000_0000, 3'b010, 1},
            '{"neg_one",   32'hBF80_0000, 32'hFFFF_FFFF, 3'b000, 10},
            '{"tie_2p5",   32'h4020_0000, 32'h0000_0002, 3'b001, 10},
            '{"neg_ovf",   32'hCF00_0001, 32'h8000_0000, 3'b010, 1},
            '{"neg_zero",  32'h8000_0000, 32'h0,         3'b000, 1},
            '{"exact_2p23",32'h4B00_0001, 32'h0080_0001, 3'b000, 4},
            '{"neg_123p75",32'hC2F7_8000, R_M123,        3'b001, 9}
        };

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 32'h0;
        out_ready    = 1'b1;
        sw_in_valid  = 1'b0;
        sw_in_data   = 32'h0;
        sw_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_out_flags", {29'h0, out_flags}, 32'h0);
        check("reset_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            send(vecs[i].name, vecs[i].din, vecs[i].d, vecs[i].f, vecs[i].lat, acc);
        end
        drain();

        // Backpressure: hold out_ready low for five cycles of out_valid.
        out_ready = 1'b0;
        send("bp_first", 32'h3FC0_0000, R_1P5, 3'b001, 10, acc);
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
            check("bp_out_valid", {31'h0, out_valid}, 32'h1);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        p0        = cyc;
        out_ready = 1'b1;
        send("bp_second", 32'h4020_0000, 32'h0000_0002, 3'b001, 10, acc);
        check("bp_accept_cycle", 32'(acc), 32'(p0 + 2));
        drain();

        // Reset while the conversion is still shifting.
        send("rst_discard", 32'h3F80_0000, 32'h1, 3'b000, 10, acc);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_out_data", out_data, 32'h0);
        check("midrst_out_flags", {29'h0, out_flags}, 32'h0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        send("after_rst_123", 32'h42F6_0000, 32'd123, 3'b000, 9, acc);
        drain();

        // STEP sweep on 1.5: only latency differs.
        sw_lat     = '{33, 18, 6};
        sw_in_data = 32'h3FC0_0000;
        sw_in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("sweep_in_ready", {31'h0, sw_in_ready[k]}, 32'h1);
        sw_acc = cyc + 1;
        @(posedge clk);
        #1;
        sw_in_valid = 1'b0;
        done   = '{1'b0, 1'b0, 1'b0};
        waited = 0;
        while (!(done[0] && done[1] && done[2]) && waited < 60) begin
            @(negedge clk);
            waited++;
            for (int k = 0; k < 3; k++) begin
                if (!done[k] && sw_out_valid[k]) begin
                    check($sformatf("sweep%0d_data", k), sw_out_data[k], R_1P5);
                    check($sformatf("sweep%0d_flags", k), {29'h0, sw_out_flags[k]}, 32'h1);
                    check($sformatf("sweep%0d_latency", k), 32'(cyc - sw_acc + 1), 32'(sw_lat[k]));
                    done[k] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (!done[k]) begin
                checks++;
                failures++;
                $display("FAIL sweep%0d_timeout: got no out_valid expected one within 60 cycles", k);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
